// File: rtl/hazard_stall_ctrl.sv
// Hazard stall controller: detects load-use and load-to-branch RAW hazards that
// forwarding cannot cover, drives PC/IF-ID hold, ID/EX bubbles and IF-ID flushes.
module hazard_stall_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [4:0]       RsAddr_D,
  input  logic [4:0]       RtAddr_D,
  input  logic             UseRs_D,
  input  logic             UseRt_D,
  input  logic             Branch_D,
  input  logic             BranchTaken_D,
  input  logic             Jump_D,
  input  logic [4:0]       RegDstAddr_E,
  input  logic             RegWriteEN_E,
  input  logic             MemRead_E,
  input  logic [4:0]       RegDstAddr_M,
  input  logic             MemRead_M,
  output logic             STALL,
  output logic             PCWriteEN,
  output logic             IFIDWriteEN,
  output logic             IDEXFlush,
  output logic             IFIDFlush,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] FlushCnt
);

  typedef enum logic [0:0] {
    RUN  = 1'b0,
    HOLD = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

  state_t           state_r;
  logic [CNT_W-1:0] stall_cnt_r;
  logic [CNT_W-1:0] flush_cnt_r;

  logic m_e_s;
  logic m_m_s;
  logic load_e_s;
  logic h2_s;
  logic h1_s;
  logic stall_s;
  logic redirect_s;
  logic flush_s;

  // Hazard detection and the raw stall/flush decisions, independent of reset.
  always_comb begin
    m_e_s      = 1'b0;
    m_m_s      = 1'b0;
    load_e_s   = 1'b0;
    h2_s       = 1'b0;
    h1_s       = 1'b0;
    stall_s    = 1'b0;
    redirect_s = 1'b0;
    flush_s    = 1'b0;

    m_e_s = (RegDstAddr_E != 5'd0) &&
            ((UseRs_D && (RsAddr_D == RegDstAddr_E)) ||
             (UseRt_D && (RtAddr_D == RegDstAddr_E)));
    m_m_s = (RegDstAddr_M != 5'd0) &&
            ((UseRs_D && (RsAddr_D == RegDstAddr_M)) ||
             (UseRt_D && (RtAddr_D == RegDstAddr_M)));
    load_e_s = MemRead_E && RegWriteEN_E;

    case (state_r)
      RUN: begin
        h2_s    = Branch_D && load_e_s && m_e_s;
        h1_s    = !h2_s && ((load_e_s && m_e_s) || (Branch_D && MemRead_M && m_m_s));
        stall_s = h2_s || h1_s;
      end
      // Second cycle of a load-to-branch stall: detection is masked.
      HOLD: begin
        stall_s = 1'b1;
      end
      default: begin
        stall_s = 1'b0;
      end
    endcase

    redirect_s = Jump_D || (Branch_D && BranchTaken_D);
    flush_s    = !stall_s && redirect_s;
  end

  // Output muxing; reset forces a safe pipeline-squash pattern.
  always_comb begin
    STALL       = 1'b0;
    PCWriteEN   = 1'b0;
    IFIDWriteEN = 1'b0;
    IDEXFlush   = 1'b1;
    IFIDFlush   = 1'b1;
    StallCnt    = CNT_ZERO;
    FlushCnt    = CNT_ZERO;
    if (RST) begin
      STALL       = 1'b0;
      PCWriteEN   = 1'b0;
      IFIDWriteEN = 1'b0;
      IDEXFlush   = 1'b1;
      IFIDFlush   = 1'b1;
      StallCnt    = CNT_ZERO;
      FlushCnt    = CNT_ZERO;
    end else begin
      STALL       = stall_s;
      PCWriteEN   = !stall_s;
      IFIDWriteEN = !stall_s;
      IDEXFlush   = stall_s;
      IFIDFlush   = flush_s;
      StallCnt    = stall_cnt_r;
      FlushCnt    = flush_cnt_r;
    end
  end

  // FSM state and saturating event counters.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= RUN;
      stall_cnt_r <= CNT_ZERO;
      flush_cnt_r <= CNT_ZERO;
    end else begin
      case (state_r)
        RUN:     state_r <= h2_s ? HOLD : RUN;
        HOLD:    state_r <= RUN;
        default: state_r <= RUN;
      endcase
      if (stall_s && (stall_cnt_r != CNT_MAX)) begin
        stall_cnt_r <= stall_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        stall_cnt_r <= stall_cnt_r;
      end
      if (flush_s && (flush_cnt_r != CNT_MAX)) begin
        flush_cnt_r <= flush_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
        flush_cnt_r <= flush_cnt_r;
      end
    end
  end

endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// Directed self-checking bench for hazard_stall_ctrl; a second CNT_W=4 instance
// shares the stimulus so counter saturation can be observed.
module tb_hazard_stall_ctrl;

  logic        CLK = 1'b0;
  logic        RST;
  logic [4:0]  RsAddr_D, RtAddr_D, RegDstAddr_E, RegDstAddr_M;
  logic        UseRs_D, UseRt_D, Branch_D, BranchTaken_D, Jump_D;
  logic        RegWriteEN_E, MemRead_E, MemRead_M;
  logic        STALL, PCWriteEN, IFIDWriteEN, IDEXFlush, IFIDFlush;
  logic [15:0] StallCnt, FlushCnt;
  logic        STALL4, PCWriteEN4, IFIDWriteEN4, IDEXFlush4, IFIDFlush4;
  logic [3:0]  StallCnt4, FlushCnt4;

  int n_cmp = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  hazard_stall_ctrl #(.CNT_W(16)) dut (
    .CLK(CLK), .RST(RST),
    .RsAddr_D(RsAddr_D), .RtAddr_D(RtAddr_D),
    .UseRs_D(UseRs_D), .UseRt_D(UseRt_D),
    .Branch_D(Branch_D), .BranchTaken_D(BranchTaken_D), .Jump_D(Jump_D),
    .RegDstAddr_E(RegDstAddr_E), .RegWriteEN_E(RegWriteEN_E), .MemRead_E(MemRead_E),
    .RegDstAddr_M(RegDstAddr_M), .MemRead_M(MemRead_M),
    .STALL(STALL), .PCWriteEN(PCWriteEN), .IFIDWriteEN(IFIDWriteEN),
    .IDEXFlush(IDEXFlush), .IFIDFlush(IFIDFlush),
    .StallCnt(StallCnt), .FlushCnt(FlushCnt)
  );

  hazard_stall_ctrl #(.CNT_W(4)) dut4 (
    .CLK(CLK), .RST(RST),
    .RsAddr_D(RsAddr_D), .RtAddr_D(RtAddr_D),
    .UseRs_D(UseRs_D), .UseRt_D(UseRt_D),
    .Branch_D(Branch_D), .BranchTaken_D(BranchTaken_D), .Jump_D(Jump_D),
    .RegDstAddr_E(RegDstAddr_E), .RegWriteEN_E(RegWriteEN_E), .MemRead_E(MemRead_E),
    .RegDstAddr_M(RegDstAddr_M), .MemRead_M(MemRead_M),
    .STALL(STALL4), .PCWriteEN(PCWriteEN4), .IFIDWriteEN(IFIDWriteEN4),
    .IDEXFlush(IDEXFlush4), .IFIDFlush(IFIDFlush4),
    .StallCnt(StallCnt4), .FlushCnt(FlushCnt4)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_inputs();
    RsAddr_D = 5'd0; RtAddr_D = 5'd0; UseRs_D = 1'b0; UseRt_D = 1'b0;
    Branch_D = 1'b0; BranchTaken_D = 1'b0; Jump_D = 1'b0;
    RegDstAddr_E = 5'd0; RegWriteEN_E = 1'b0; MemRead_E = 1'b0;
    RegDstAddr_M = 5'd0; MemRead_M = 1'b0;
  endtask

  task automatic load_use();
    MemRead_E = 1'b1; RegWriteEN_E = 1'b1; RegDstAddr_E = 5'd8;
    UseRs_D = 1'b1; RsAddr_D = 5'd8;
  endtask

  initial begin
    RST = 1'b1;
    clear_inputs();
    tick();
    tick();
    // Forced outputs during reset
    check("rst_stall",   {31'd0, STALL},       32'd0);
    check("rst_pcwe",    {31'd0, PCWriteEN},   32'd0);
    check("rst_ifidwe",  {31'd0, IFIDWriteEN}, 32'd0);
    check("rst_idexfl",  {31'd0, IDEXFlush},   32'd1);
    check("rst_ifidfl",  {31'd0, IFIDFlush},   32'd1);
    check("rst_scnt",    {16'd0, StallCnt},    32'd0);
    check("rst_fcnt",    {16'd0, FlushCnt},    32'd0);

    RST = 1'b0;
    #1;
    check("idle_stall",  {31'd0, STALL},       32'd0);
    check("idle_pcwe",   {31'd0, PCWriteEN},   32'd1);
    check("idle_idexfl", {31'd0, IDEXFlush},   32'd0);
    check("idle_ifidfl", {31'd0, IFIDFlush},   32'd0);
    tick();

    // Load-use: one stall cycle
    load_use();
    #1;
    check("lu_stall",    {31'd0, STALL},       32'd1);
    check("lu_pcwe",     {31'd0, PCWriteEN},   32'd0);
    check("lu_ifidwe",   {31'd0, IFIDWriteEN}, 32'd0);
    check("lu_idexfl",   {31'd0, IDEXFlush},   32'd1);
    tick();
    clear_inputs();
    UseRs_D = 1'b1; RsAddr_D = 5'd8; MemRead_M = 1'b1; RegDstAddr_M = 5'd8;
    #1;
    check("lu_next_stall", {31'd0, STALL}, 32'd0);
    check("lu_scnt",       {16'd0, StallCnt}, 32'd1);
    tick();
    check("lu_scnt_hold",  {16'd0, StallCnt}, 32'd1);

    // Load then beq: two stall cycles, then taken-branch flush
    clear_inputs();
    MemRead_E = 1'b1; RegWriteEN_E = 1'b1; RegDstAddr_E = 5'd9;
    Branch_D = 1'b1; UseRt_D = 1'b1; RtAddr_D = 5'd9;
    #1;
    check("lb_stall1",  {31'd0, STALL},     32'd1);
    check("lb_ifidfl1", {31'd0, IFIDFlush}, 32'd0);
    tick();
    MemRead_E = 1'b0; RegWriteEN_E = 1'b0; RegDstAddr_E = 5'd0;
    MemRead_M = 1'b1; RegDstAddr_M = 5'd9;
    #1;
    check("lb_stall2",  {31'd0, STALL},     32'd1);
    check("lb_ifidfl2", {31'd0, IFIDFlush}, 32'd0);
    tick();
    MemRead_M = 1'b0; RegDstAddr_M = 5'd0; BranchTaken_D = 1'b1;
    #1;
    check("lb_stall3",  {31'd0, STALL},     32'd0);
    check("lb_ifidfl3", {31'd0, IFIDFlush}, 32'd1);
    tick();
    check("lb_fcnt",    {16'd0, FlushCnt},  32'd1);
    check("lb_scnt",    {16'd0, StallCnt},  32'd3);

    // No false hazards
    clear_inputs();
    RegWriteEN_E = 1'b1; RegDstAddr_E = 5'd8; Branch_D = 1'b1; UseRs_D = 1'b1; RsAddr_D = 5'd8;
    #1;
    check("nf_alu_beq", {31'd0, STALL}, 32'd0);
    clear_inputs();
    MemRead_E = 1'b1; RegWriteEN_E = 1'b1; RegDstAddr_E = 5'd0; UseRs_D = 1'b1; RsAddr_D = 5'd0;
    #1;
    check("nf_r0", {31'd0, STALL}, 32'd0);
    clear_inputs();
    MemRead_E = 1'b1; RegWriteEN_E = 1'b1; RegDstAddr_E = 5'd8; RsAddr_D = 5'd8;
    #1;
    check("nf_nouse", {31'd0, STALL}, 32'd0);

    // Branch in ID against a load in MEM: one stall cycle
    clear_inputs();
    Branch_D = 1'b1; UseRs_D = 1'b1; RsAddr_D = 5'd5; MemRead_M = 1'b1; RegDstAddr_M = 5'd5;
    #1;
    check("bm_stall", {31'd0, STALL}, 32'd1);
    tick();
    clear_inputs();
    #1;
    check("bm_stall_after", {31'd0, STALL},    32'd0);
    check("bm_scnt",        {16'd0, StallCnt}, 32'd4);

    // Jump during a load-use stall: flush deferred
    load_use();
    Jump_D = 1'b1;
    #1;
    check("js_stall",  {31'd0, STALL},     32'd1);
    check("js_ifidfl", {31'd0, IFIDFlush}, 32'd0);
    tick();
    clear_inputs();
    Jump_D = 1'b1;
    #1;
    check("js_stall2",  {31'd0, STALL},     32'd0);
    check("js_ifidfl2", {31'd0, IFIDFlush}, 32'd1);
    tick();
    clear_inputs();
    #1;
    check("js_scnt", {16'd0, StallCnt}, 32'd5);
    check("js_fcnt", {16'd0, FlushCnt}, 32'd2);

    // Reset mid-HOLD
    MemRead_E = 1'b1; RegWriteEN_E = 1'b1; RegDstAddr_E = 5'd9;
    Branch_D = 1'b1; UseRt_D = 1'b1; RtAddr_D = 5'd9;
    tick();
    check("rh_hold_stall", {31'd0, STALL},    32'd1);
    check("rh_scnt",       {16'd0, StallCnt}, 32'd6);
    RST = 1'b1;
    #1;
    check("rh_stall",  {31'd0, STALL},     32'd0);
    check("rh_idexfl", {31'd0, IDEXFlush}, 32'd1);
    check("rh_ifidfl", {31'd0, IFIDFlush}, 32'd1);
    check("rh_pcwe",   {31'd0, PCWriteEN}, 32'd0);
    tick();
    RST = 1'b0;
    clear_inputs();
    #1;
    check("rh_run_stall", {31'd0, STALL},    32'd0);
    check("rh_run_scnt",  {16'd0, StallCnt}, 32'd0);
    check("rh_run_fcnt",  {16'd0, FlushCnt}, 32'd0);
    check("rh_run_scnt4", {28'd0, StallCnt4}, 32'd0);

    // Saturation on the narrow instance
    load_use();
    for (int i = 0; i < 14; i++) tick();
    check("sat_14", {28'd0, StallCnt4}, 32'd14);
    tick();
    check("sat_15", {28'd0, StallCnt4}, 32'd15);
    for (int i = 0; i < 5; i++) tick();
    check("sat_hold",    {28'd0, StallCnt4}, 32'd15);
    check("sat_wide",    {16'd0, StallCnt},  32'd20);
    check("sat_stall4",  {31'd0, STALL4},    32'd1);
    check("sat_fcnt4",   {28'd0, FlushCnt4}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/hazard_stall_ctrl.md
Name: hazard_stall_ctrl

Overview:
- Producer of the STALL signal consumed by the forwarding unit.
- Detects the RAW hazards that forwarding cannot cover: load-use, and branch-in-decode against a load.
- Drives PC / IF-ID hold, ID/EX bubble insertion and IF-ID flush on taken branches or jumps.
- A small FSM handles 2-cycle stalls; saturating counters record stall and flush cycles.

Parameters:
- CNT_W, 16, width of the StallCnt and FlushCnt counters.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  reset; synchronous, active-high.
- RsAddr_D  in  5  rs field of the instruction in ID.
- RtAddr_D  in  5  rt field of the instruction in ID.
- UseRs_D  in  1  ID instruction reads rs.
- UseRt_D  in  1  ID instruction reads rt.
- Branch_D  in  1  ID instruction is beq/bne (compared in ID).
- BranchTaken_D  in  1  ID branch compare result.
- Jump_D  in  1  ID instruction is j/jal.
- RegDstAddr_E  in  5  destination register of the EX instruction.
- RegWriteEN_E  in  1  EX instruction writes a register.
- MemRead_E  in  1  EX instruction is a load.
- RegDstAddr_M  in  5  destination register of the MEM instruction.
- MemRead_M  in  1  MEM instruction is a load.
- STALL  out  1  hazard stall; the forwarding unit is active only when STALL=0.
- PCWriteEN  out  1  PC write enable.
- IFIDWriteEN  out  1  IF/ID register write enable.
- IDEXFlush  out  1  insert a bubble into ID/EX.
- IFIDFlush  out  1  squash the IF/ID contents.
- StallCnt  out  CNT_W  saturating count of cycles with STALL=1.
- FlushCnt  out  CNT_W  saturating count of cycles with IFIDFlush=1.

Behaviour:
- Match terms (a register index of 0 never matches):
  - mE = RegDstAddr_E != 0 && ((UseRs_D && RsAddr_D == RegDstAddr_E) || (UseRt_D && RtAddr_D == RegDstAddr_E)).
  - mM is the same test against RegDstAddr_M.
- Hazard classes, evaluated only in state RUN:
  - H2 = Branch_D && MemRead_E && RegWriteEN_E && mE. Load in EX feeding a branch needs 2 stall cycles.
  - H1 = !H2 && ((MemRead_E && RegWriteEN_E && mE) || (Branch_D && MemRead_M && mM)). Needs 1 stall cycle.
  - An ALU producer in EX or MEM is never a hazard; the forwarding unit covers it.
- FSM states: RUN and HOLD.
  - RUN with H2: STALL=1 this cycle, next state HOLD.
  - RUN with H1: STALL=1, stay in RUN. The next cycle is re-evaluated with the bubble in place.
  - RUN with neither: STALL=0.
  - HOLD: STALL=1 unconditionally, detection masked, next state RUN.
  - No other transitions.
- STALL is combinational from the inputs and the state; there is zero-cycle latency from hazard to STALL.
- Derived outputs when RST=0:
  - PCWriteEN = IFIDWriteEN = !STALL.
  - IDEXFlush = STALL.
  - IFIDFlush = !STALL && (Jump_D || (Branch_D && BranchTaken_D)).
- Simultaneous stall and taken branch or jump: the stall wins and IFIDFlush=0. The flush occurs on the first non-stalled cycle.
- Counters:
  - StallCnt increments on each edge where STALL=1 and RST=0.
  - FlushCnt increments on each edge where IFIDFlush=1 and RST=0.
  - Both hold at 2^CNT_W-1 (no wrap).
- Reset, on any edge with RST=1 (including mid-HOLD):
  - State goes to RUN; StallCnt and FlushCnt go to 0.
  - While RST=1 the outputs are forced: STALL=0, PCWriteEN=0, IFIDWriteEN=0, IDEXFlush=1, IFIDFlush=1, and the counters read 0.
- The first cycle after RST falls is evaluated normally in RUN.

Test Plan:
- Load-use: EX holds a load with RegDstAddr_E=8 and RegWriteEN_E=1; ID has UseRs_D=1, RsAddr_D=8 (add) -> STALL=1, PCWriteEN=0, IDEXFlush=1 for exactly 1 cycle; next cycle (load in M, non-branch) STALL=0; StallCnt=1.
- Load then beq: EX load with dst 9; ID beq with RtAddr_D=9, UseRt_D=1 -> STALL=1 for 2 cycles (RUN, then HOLD), IFIDFlush=0 throughout; third cycle with BranchTaken_D=1 -> STALL=0, IFIDFlush=1, FlushCnt=1.
- No false hazard:
  - ALU write to 8 in EX feeding beq rs=8 -> STALL=0.
  - Load to $0 with RsAddr_D=0 -> STALL=0.
  - Load to 8 with RsAddr_D=8 but UseRs_D=0 -> STALL=0.
- Reset mid-HOLD: trigger H2, assert RST on the HOLD cycle -> next cycle state RUN, StallCnt=0; during RST STALL=0, IDEXFlush=1, IFIDFlush=1, PCWriteEN=0.
- Saturation: CNT_W=4, hold a load-use hazard pattern for 20 cycles -> StallCnt reaches 15 and stays at 15.
- Jump during stall: Jump_D=1 with an H1 hazard present -> IFIDFlush=0 while STALL=1; IFIDFlush=1 on the following unstalled cycle.
